result_drain: RTL and testbench

//   Downstream readout stage for the accumulator/pooling block. Takes a host command
//   (source, base, length), issues rden/rdptr reads to one of the three result buffers
//   (SA conv data, FC data, pool address), absorbs the 1-cycle read latency and emits the

---
 rtl/top_pkg.sv | 32 +++
 rtl/drain_fifo.sv | 64 ++++++
 rtl/result_drain.sv | 203 ++++++++++++++++++++
 tb/tb_result_drain.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared definitions for the result readout path.
// Holds the buffer pointer/data widths used by the accumulator/pooling block and
// result_drain, the command source and FSM state enums, and a zero-extension helper.
package top_pkg;

    localparam int unsigned DATA_WIDTH = 8;   // SA/FC result word width
    localparam int unsigned SA_PTR_W   = 14;  // SA data read pointer width
    localparam int unsigned FC_PTR_W   = 10;  // FC data read pointer width
    localparam int unsigned PL_PTR_W   = 14;  // pool address read pointer width
    localparam int unsigned PL_DATA_W  = 10;  // pool word width and stream width
    localparam int unsigned CMD_W      = 14;  // command base/length width
    localparam int unsigned FIFO_DEPTH = 4;   // >= 3 sustains 1 word/clk
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_SA   = 2'd0,
        SRC_FC   = 2'd1,
        SRC_POOL = 2'd2,
        SRC_RSV  = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    function automatic logic [PL_DATA_W-1:0] zext_data(input logic [DATA_WIDTH-1:0] d);
        return {{(PL_DATA_W - DATA_WIDTH){1'b0}}, d};
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO for the readout stream.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write side (push ignored when full)
//   pop             read side (ignored when empty)
//   pop_data        head entry, valid whenever count != 0, stable until popped
//   count           current occupancy, used by the producer for credit
module drain_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_push  = push && (count != CNT_W'(DEPTH));
    assign do_pop   = pop && (count != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_drain.sv
// Readout stage for the accumulator/pooling result buffers.
// Accepts one (src, base, len) command at a time, reads len words from the selected
// buffer (SA data, FC data or pool address) with 1-cycle read latency and streams them
// out on a valid/ready interface with a last marker.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cmd_*                      command handshake, source, base pointer, word count
//   sa_data_* / fc_data_*      SA / FC buffer read port (rden, rdptr, rdata)
//   pool_address_*             pool address buffer read port
//   m_valid_o/m_ready_i        output stream handshake, m_data_o word, m_last_o marker
//   busy_o, done_o, err_o      status: busy, completion pulse, reserved-source pulse
module result_drain
    import top_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_src_i,
    input  logic [CMD_W-1:0]      cmd_base_i,
    input  logic [CMD_W-1:0]      cmd_len_i,
    output logic                  sa_data_rden_o,
    output logic [SA_PTR_W-1:0]   sa_data_rdptr_o,
    input  logic [DATA_WIDTH-1:0] sa_data_rdata_i,
    output logic                  fc_data_rden_o,
    output logic [FC_PTR_W-1:0]   fc_data_rdptr_o,
    input  logic [DATA_WIDTH-1:0] fc_data_rdata_i,
    output logic                  pool_address_rden_o,
    output logic [PL_PTR_W-1:0]   pool_address_rdptr_o,
    input  logic [PL_DATA_W-1:0]  pool_address_rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [PL_DATA_W-1:0]  m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    state_e               state;
    state_e               state_nxt;
    src_e                 src_q;
    logic [CMD_W-1:0]     base_q;
    logic [CMD_W-1:0]     len_q;
    logic [CMD_W-1:0]     issued;
    logic [CMD_W-1:0]     rd_ptr;
    logic                 rdy_en;
    logic                 accept;
    logic                 issue;
    logic                 last_issue;
    logic                 credit_ok;
    logic                 done_set;
    logic                 err_set;
    logic                 done_q;
    logic                 err_q;
    logic                 infl_v;
    logic                 infl_last;
    logic [PL_DATA_W-1:0] rd_word;
    logic [SA_PTR_W-1:0]  sa_ptr_q;
    logic [FC_PTR_W-1:0]  fc_ptr_q;
    logic [PL_PTR_W-1:0]  pl_ptr_q;
    logic [CNT_W-1:0]     fifo_cnt;
    logic [CNT_W:0]       used;
    logic [PL_DATA_W:0]   fifo_dout;
    logic                 pop;

    // rdy_en keeps cmd_ready_o low during reset and for the first cycle it is released.
    assign cmd_ready_o = rdy_en && (state == ST_IDLE);
    assign busy_o      = (state != ST_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign accept      = cmd_valid_i && cmd_ready_o;

    // Credit counts both buffered words and the read still in the latency stage.
    assign used       = {1'b0, fifo_cnt} + (CNT_W + 1)'(infl_v);
    assign credit_ok  = used < (CNT_W + 1)'(FIFO_DEPTH);
    assign last_issue = (issued == len_q - CMD_W'(1));
    assign rd_ptr     = base_q + issued;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (src_e'(cmd_src_i) == SRC_RSV) begin
                        done_set = 1'b1;
                        err_set  = 1'b1;
                    end else if (cmd_len_i == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_issue) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge that pops the final word so done lands one cycle later.
                if (!infl_v && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop))) begin
                    state_nxt = ST_IDLE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read ports: pointer is live while reading, otherwise the last issued value is held.
    assign sa_data_rden_o       = issue && (src_q == SRC_SA);
    assign fc_data_rden_o       = issue && (src_q == SRC_FC);
    assign pool_address_rden_o  = issue && (src_q == SRC_POOL);
    assign sa_data_rdptr_o      = sa_data_rden_o ? rd_ptr[SA_PTR_W-1:0] : sa_ptr_q;
    assign fc_data_rdptr_o      = fc_data_rden_o ? rd_ptr[FC_PTR_W-1:0] : fc_ptr_q;
    assign pool_address_rdptr_o = pool_address_rden_o ? rd_ptr[PL_PTR_W-1:0] : pl_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_en    <= 1'b0;
            src_q     <= SRC_SA;
            base_q    <= '0;
            len_q     <= '0;
            issued    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            infl_v    <= 1'b0;
            infl_last <= 1'b0;
            sa_ptr_q  <= '0;
            fc_ptr_q  <= '0;
            pl_ptr_q  <= '0;
        end else begin
            rdy_en    <= 1'b1;
            done_q    <= done_set;
            err_q     <= err_set;
            infl_v    <= issue;
            infl_last <= issue && last_issue;
            if (accept) begin
                src_q  <= src_e'(cmd_src_i);
                base_q <= cmd_base_i;
                len_q  <= cmd_len_i;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + CMD_W'(1);
            end
            if (sa_data_rden_o) begin
                sa_ptr_q <= sa_data_rdptr_o;
            end
            if (fc_data_rden_o) begin
                fc_ptr_q <= fc_data_rdptr_o;
            end
            if (pool_address_rden_o) begin
                pl_ptr_q <= pool_address_rdptr_o;
            end
        end
    end

    // src_q cannot change while a read is in flight, so it selects the returning data.
    always_comb begin
        rd_word = zext_data(sa_data_rdata_i);
        case (src_q)
            SRC_FC:   rd_word = zext_data(fc_data_rdata_i);
            SRC_POOL: rd_word = pool_address_rdata_i;
            default:  ;
        endcase
    end

    assign pop = m_valid_o && m_ready_i;

    drain_fifo #(
        .WIDTH(PL_DATA_W + 1),
        .DEPTH(FIFO_DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (infl_v),
        .push_data({infl_last, rd_word}),
        .pop      (pop),
        .pop_data (fifo_dout),
        .count    (fifo_cnt)
    );

    assign m_valid_o = (fifo_cnt != '0);
    assign m_data_o  = m_valid_o ? fifo_dout[PL_DATA_W-1:0] : '0;
    assign m_last_o  = m_valid_o && fifo_dout[PL_DATA_W];

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_src;
    logic [13:0] cmd_base;
    logic [13:0] cmd_len;
    logic        sa_rden;
    logic [13:0] sa_rdptr;
    logic [7:0]  sa_rdata;
    logic        fc_rden;
    logic [9:0]  fc_rdptr;
    logic [7:0]  fc_rdata;
    logic        pl_rden;
    logic [13:0] pl_rdptr;
    logic [9:0]  pl_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [9:0]  m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    result_drain dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_src_i           (cmd_src),
        .cmd_base_i          (cmd_base),
        .cmd_len_i           (cmd_len),
        .sa_data_rden_o      (sa_rden),
        .sa_data_rdptr_o     (sa_rdptr),
        .sa_data_rdata_i     (sa_rdata),
        .fc_data_rden_o      (fc_rden),
        .fc_data_rdptr_o     (fc_rdptr),
        .fc_data_rdata_i     (fc_rdata),
        .pool_address_rden_o (pl_rden),
        .pool_address_rdptr_o(pl_rdptr),
        .pool_address_rdata_i(pl_rdata),
        .m_valid_o           (m_valid),
        .m_ready_i           (m_ready),
        .m_data_o            (m_data),
        .m_last_o            (m_last),
        .busy_o              (busy),
        .done_o              (done),
        .err_o               (err)
    );

    // Result buffers with 1-cycle read latency
    logic [7:0] sa_mem [16384];
    logic [7:0] fc_mem [1024];
    logic [9:0] pl_mem [16384];

    always @(posedge clk) begin
        if (sa_rden) sa_rdata <= sa_mem[sa_rdptr];
        if (fc_rden) fc_rdata <= fc_mem[fc_rdptr];
        if (pl_rden) pl_rdata <= pl_mem[pl_rdptr];
    end

    int tests = 0;
    int fails = 0;

    // Reference model: expected reads and words of the current command
    int         exp_ptr_q[$];
    logic [9:0] exp_word_q[$];
    bit         exp_last_q[$];
    int         outstanding;
    int         cur_src;
    int         hs;
    int         first_valid;
    int         last_hs;
    int         issued_idx;
    int         last_ptr[3];
    bit         cmd_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ptr_mask(input int s);
        return (s == 1) ? 1023 : 16383;
    endfunction

    function automatic logic [9:0] mem_word(input int s, input int p);
        case (s)
            0:       return {2'b00, sa_mem[p]};
            1:       return {2'b00, fc_mem[p]};
            default: return pl_mem[p];
        endcase
    endfunction

    function automatic logic [2:0] src_onehot(input int s);
        case (s)
            0:       return 3'b100;
            1:       return 3'b010;
            2:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] outs_vec();
        return {7'd0, cmd_ready, sa_rden, sa_rdptr, fc_rden, fc_rdptr, pl_rden, pl_rdptr,
                m_valid, m_data, m_last, busy, done, err};
    endfunction

    task automatic reset_model();
        exp_ptr_q.delete();
        exp_word_q.delete();
        exp_last_q.delete();
        outstanding = 0;
        for (int i = 0; i < 3; i++) last_ptr[i] = 0;
    endtask

    // One clock of checks; called at #1 after the active edge.
    task automatic check_cycle(input int t, input int mode, input bit rsv, input int n_words);
        logic [2:0] rd;
        bit         exp_done;
        int         p;
        int         obs_ptr;
        case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (t % 2 == 0);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
        exp_done = (hs == n_words);

        rd = {sa_rden, fc_rden, pl_rden};
        if (rd != 3'b000) begin
            chk("rden_select", 64'(rd), 64'(src_onehot(cur_src)));
            chk("credit", 64'(outstanding < 4), 64'd1);
            chk("read_expected", 64'(exp_ptr_q.size() > 0), 64'd1);
            if (exp_ptr_q.size() > 0) begin
                p = exp_ptr_q.pop_front();
                obs_ptr = sa_rden ? int'(sa_rdptr) : (fc_rden ? int'(fc_rdptr) : int'(pl_rdptr));
                chk("rdptr", 64'(obs_ptr), 64'(p));
                if (cur_src < 3) last_ptr[cur_src] = p;
                if (mode == 0) chk("issue_cycle", 64'(t), 64'(issued_idx));
                issued_idx++;
                outstanding++;
            end
        end
        if (!sa_rden) chk("sa_rdptr_hold", 64'(sa_rdptr), 64'(last_ptr[0]));
        if (!fc_rden) chk("fc_rdptr_hold", 64'(fc_rdptr), 64'(last_ptr[1]));
        if (!pl_rden) chk("pl_rdptr_hold", 64'(pl_rdptr), 64'(last_ptr[2]));

        if (m_valid) begin
            if (first_valid < 0) first_valid = t;
            chk("word_expected", 64'(exp_word_q.size() > 0), 64'd1);
            if (exp_word_q.size() > 0) begin
                chk("m_data", 64'(m_data), 64'(exp_word_q[0]));
                chk("m_last", 64'(m_last), 64'(exp_last_q[0]));
                if (m_ready) begin
                    void'(exp_word_q.pop_front());
                    void'(exp_last_q.pop_front());
                    hs++;
                    last_hs = t;
                    outstanding--;
                end
            end
        end

        chk("err", 64'(err), 64'(rsv && t == 0));
        chk("done", 64'(done), 64'(exp_done));
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_done));
        chk("busy", 64'(busy), 64'(!exp_done));
        cmd_done = exp_done;
    endtask

    task automatic run_cmd(input int src, input int base, input int len, input int mode,
                           input int abort_hs, input bit hold, input int hsrc,
                           input int hbase, input int hlen, input bit immediate);
        int w;
        int t;
        int n_words;
        int p;
        bit rsv;
        rsv         = (src == 3);
        n_words     = rsv ? 0 : len;
        cur_src     = src;
        hs          = 0;
        first_valid = -1;
        last_hs     = -1;
        issued_idx  = 0;
        cmd_done    = 1'b0;
        for (int i = 0; i < n_words; i++) begin
            p = (base + i) & ptr_mask(src);
            exp_ptr_q.push_back(p);
            exp_word_q.push_back(mem_word(src, p));
            exp_last_q.push_back(i == n_words - 1);
        end
        cmd_valid = 1'b1;
        cmd_src   = 2'(src);
        cmd_base  = 14'(base);
        cmd_len   = 14'(len);
        w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'd1);
        if (immediate) chk("held_accept_delay", 64'(w), 64'd0);
        tick();
        cmd_valid = hold;
        if (hold) begin
            cmd_src  = 2'(hsrc);
            cmd_base = 14'(hbase);
            cmd_len  = 14'(hlen);
        end
        t = 0;
        while (t < 40 + 4 * len) begin
            check_cycle(t, mode, rsv, n_words);
            if (cmd_done) break;
            if (abort_hs >= 0 && hs >= abort_hs) return;
            tick();
            t++;
        end
        chk("cmd_completed", 64'(cmd_done), 64'd1);
        chk("reads_left", 64'(exp_ptr_q.size()), 64'd0);
        chk("words_left", 64'(exp_word_q.size()), 64'd0);
        if (n_words > 0) chk("first_valid_cycle", 64'(first_valid), 64'd2);
        if (n_words > 0 && mode == 0) chk("back_to_back", 64'(last_hs), 64'(n_words + 1));
    endtask

    initial begin
        int r;
        int s;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        sa_rdata  = '0;
        fc_rdata  = '0;
        pl_rdata  = '0;
        for (int i = 0; i < 16384; i++) begin
            sa_mem[i] = 8'($urandom);
            pl_mem[i] = 10'($urandom);
        end
        for (int i = 0; i < 1024; i++) fc_mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) sa_mem[i] = 8'(i + 1);
        reset_model();

        repeat (3) tick();
        chk("reset_all_zero", outs_vec(), 64'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);

        // SA base 0, len 4, always ready
        run_cmd(0, 0, 4, 0, -1, 1'b0, 0, 0, 0, 1'b0);
        // Pool base 100, len 6, alternating ready
        run_cmd(2, 100, 6, 1, -1, 1'b0, 0, 0, 0, 1'b0);
        // FC pointer wrap 1022 -> 1
        run_cmd(1, 1022, 4, 0, -1, 1'b0, 0, 0, 0, 1'b0);
        // Zero length, then reserved source
        run_cmd(0, 77, 0, 0, -1, 1'b0, 0, 0, 0, 1'b0);
        run_cmd(3, 5, 5, 0, -1, 1'b0, 0, 0, 0, 1'b0);
        // Command held valid while busy, accepted right after completion
        run_cmd(1, 10, 5, 2, -1, 1'b1, 2, 500, 3, 1'b0);
        run_cmd(2, 500, 3, 0, -1, 1'b0, 0, 0, 0, 1'b1);

        // Reset after two of eight SA words
        run_cmd(0, 200, 8, 0, 2, 1'b0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        chk("reset_mid_all_zero", outs_vec(), 64'd0);
        rst = 1'b0;
        m_ready = 1'b0;
        reset_model();
        tick();
        chk("ready_after_mid_reset", 64'(cmd_ready), 64'd1);
        run_cmd(0, 0, 2, 0, -1, 1'b0, 0, 0, 0, 1'b0);

        // Randomized commands
        for (int k = 0; k < 12; k++) begin
            r = $urandom_range(0, 9);
            s = (r < 3) ? 0 : ((r < 6) ? 1 : ((r < 9) ? 2 : 3));
            run_cmd(s, $urandom_range(0, 16383), $urandom_range(0, 24), $urandom_range(0, 2),
                    -1, 1'b0, 0, 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
